bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, 1024, max cycles from grant to s_done before forced release.
REQ-002 Parameter NUM_SLAVES, 3, number of slave ports; slave-id values >= NUM_SLAVES are invalid.
REQ-003 Clock and reset: one clock, clk; reset rstn is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge system clock.
REQ-005 rstn  in  1  asynchronous active-low reset.
REQ-006 m1_req, m2_req  in  1 each  master bus request, level, held until s_done.
REQ-007 m1_valid, m2_valid  in  1 each  master serial valid.
REQ-008 m1_addr, m2_addr  in  1 each  master serial address line, MSB-first.
REQ-009 m1_data, m2_data  in  1 each  master serial data line.
REQ-010 m1_grant, m2_grant  out  1 each  registered grant, at most one high.
REQ-011 m1_ready, m2_ready  out  1 each  selected slave's s_ready routed to the granted master.
REQ-012 s_valid  out  NUM_SLAVES  per-slave valid, one-hot or zero.
REQ-013 s_addr, s_data  out  1 each  granted master's address/data lines, shared by all slaves.
REQ-014 s_ready  in  NUM_SLAVES  per-slave ready.
REQ-015 s_done  in  NUM_SLAVES  per-slave transaction-complete pulse.
REQ-016 err  out  1  one-cycle pulse on invalid slave-id or timeout.

Function
REQ-017 FSM states IDLE, GRANT, SLV_ID, CONNECT; transitions occur on rising clk only.
REQ-018 IDLE: grants low; any request -> GRANT, grant registered one cycle after request is sampled.
REQ-019 Both requests in IDLE: grant the master not served last; first arbitration after reset favours m1.
REQ-020 GRANT: first cycle with granted valid high -> SLV_ID, and that cycle's addr bit is captured as slave-id bit 1.
REQ-021 GRANT: granted request dropped before valid -> IDLE, grant cleared next cycle, last-served unchanged.
REQ-022 SLV_ID: next valid-high cycle captures slave-id bit 0; valid-low cycles hold the state (no capture).
REQ-023 Slave-id bits are consumed by the arbiter: s_valid stays zero during GRANT and SLV_ID.
REQ-024 Slave-id < NUM_SLAVES -> CONNECT with that slave selected; slave-id = 3 -> err pulse, IDLE, grant released.
REQ-025 CONNECT: s_valid[sel] = granted valid combinationally; s_addr/s_data = granted master's lines; other s_valid bits 0.
REQ-026 CONNECT: granted mN_ready = s_ready[sel]; non-granted ready 0; ready 0 outside CONNECT.
REQ-027 s_done[sel] in CONNECT -> IDLE, grant low next cycle, last-served = granted master; s_done of unselected slaves is ignored.
REQ-028 New arbitration begins at the earliest in the cycle after return to IDLE (one idle cycle between owners).
REQ-029 Timeout counter clears on GRANT entry and increments each cycle in GRANT/SLV_ID/CONNECT; reaching TIMEOUT-1 -> err pulse, IDLE, last-served = granted master.
REQ-030 Timeout has priority over s_done and slave-id decode in the same cycle.
REQ-031 Request drop in SLV_ID/CONNECT is ignored; only s_done or timeout release the grant.
REQ-032 s_addr/s_data driven 0 when no grant.

Reset
REQ-033 rstn low asynchronously forces IDLE, grants 0, err 0, counter 0, slave-id register 0, last-served = m2 (so m1 wins first).
REQ-034 Reset mid-transaction drops s_valid and ready outputs immediately, with no err pulse.
REQ-035 After rstn deassertion the first arbitration occurs on the first rising edge with a request.

Structure
REQ-036 Shared package serial_bus_pkg holds the FSM state enum, SLAVE_ID_W = 2, and the slave-id constants.
REQ-037 One sub-module, bus_timeout_counter (clear, enable, terminal-count flag), parameterised by TIMEOUT.
REQ-038 All outputs except s_valid/s_addr/s_data/mN_ready are registered; those four are muxes of registered select.

Verification
REQ-039 m1_req alone, id bits 0,1, then 12 addr bits, then s_done[1] -> m1_grant 1 cycle after req; s_valid[1] asserted only during the 12 addr bits; grant low 1 cycle after s_done.
REQ-040 m1_req and m2_req together after reset -> m1 granted; after s_done, m2 granted following one idle cycle.
REQ-041 m2_req with id bits 1,1 -> err pulse for 1 cycle, m2_grant low next cycle, all s_valid 0 throughout.
REQ-042 TIMEOUT=16, slave never asserts s_done -> err at cycle 15 after grant, return to IDLE.
REQ-043 rstn pulsed low mid-CONNECT -> grants, s_valid, ready at 0 immediately; m1 wins the next simultaneous request.
REQ-044 Granted master drops req in GRANT before valid -> release with no err, and the other master is granted after the idle cycle.

Source files
------------

// File: rtl/serial_bus_pkg.sv
// Shared definitions for the serial-bus arbiter: FSM states, master ids and
// slave-id encoding.
package serial_bus_pkg;

  localparam int SLAVE_ID_W = 2;

  typedef logic [SLAVE_ID_W-1:0] slave_id_t;

  localparam slave_id_t SLV_ID_0 = slave_id_t'(0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_SLV_ID  = 2'd2,
    ST_CONNECT = 2'd3
  } arb_state_e;

  typedef enum logic {
    MST_M1 = 1'b0,
    MST_M2 = 1'b1
  } master_e;

  // A slave id addresses a real port only when it is below the port count.
  function automatic logic is_valid_slave(input slave_id_t id, input int num_slaves);
    return int'(id) < num_slaves;
  endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Ownership watchdog: counts cycles while the bus is owned and flags the
// cycle whose increment brings the count to TIMEOUT-1.
module bus_timeout_counter #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear wins, otherwise step while the bus is owned.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // The release decision is registered, so it is taken one cycle early.
  assign tc = enable && !clear && (count_q == CNT_W'(TIMEOUT - 2));

  // Count register.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master, NUM_SLAVES-slave serial bus arbiter. The granted master sends a
// two-bit slave id (MSB first) on its address line, then is connected to that
// slave until s_done or the ownership timeout.
module bus_arbiter
  import serial_bus_pkg::*;
#(
  parameter int TIMEOUT    = 1024,
  parameter int NUM_SLAVES = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  m1_req,
  input  logic                  m2_req,
  input  logic                  m1_valid,
  input  logic                  m2_valid,
  input  logic                  m1_addr,
  input  logic                  m2_addr,
  input  logic                  m1_data,
  input  logic                  m2_data,
  output logic                  m1_grant,
  output logic                  m2_grant,
  output logic                  m1_ready,
  output logic                  m2_ready,
  output logic [NUM_SLAVES-1:0] s_valid,
  output logic                  s_addr,
  output logic                  s_data,
  input  logic [NUM_SLAVES-1:0] s_ready,
  input  logic [NUM_SLAVES-1:0] s_done,
  output logic                  err
);

  arb_state_e state_q, state_d;
  logic       m1_grant_q, m1_grant_d;
  logic       m2_grant_q, m2_grant_d;
  slave_id_t  slave_id_q, slave_id_d;
  master_e    last_q, last_d;
  logic       err_q, err_d;

  logic       g_req, g_valid, g_addr, g_data;
  logic       sel_ready, sel_done;
  logic       cnt_clear, cnt_enable, cnt_tc;
  logic       do_release, served;
  slave_id_t  id_next;

  // Lines of whichever master currently holds the grant; all zero when none does.
  always_comb begin
    g_req   = 1'b0;
    g_valid = 1'b0;
    g_addr  = 1'b0;
    g_data  = 1'b0;
    if (m1_grant_q) begin
      g_req   = m1_req;
      g_valid = m1_valid;
      g_addr  = m1_addr;
      g_data  = m1_data;
    end else if (m2_grant_q) begin
      g_req   = m2_req;
      g_valid = m2_valid;
      g_addr  = m2_addr;
      g_data  = m2_data;
    end
  end

  // Ready/done of the selected slave; other slaves are ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_done  = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (slave_id_q == SLAVE_ID_W'(i)) begin
        sel_ready = s_ready[i];
        sel_done  = s_done[i];
      end
    end
  end

  // Watchdog restarts on every new grant and runs for the whole ownership.
  assign cnt_clear  = (state_q == ST_IDLE) && (m1_req || m2_req);
  assign cnt_enable = (state_q != ST_IDLE);

  bus_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rstn   (rstn),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .tc     (cnt_tc)
  );

  // Arbitration, slave-id capture and release decisions.
  always_comb begin
    state_d    = state_q;
    m1_grant_d = m1_grant_q;
    m2_grant_d = m2_grant_q;
    slave_id_d = slave_id_q;
    last_d     = last_q;
    err_d      = 1'b0;
    do_release = 1'b0;
    served     = 1'b0;
    id_next    = {slave_id_q[SLAVE_ID_W-1], g_addr};

    unique case (state_q)
      ST_IDLE: begin
        if (m1_req || m2_req) begin
          state_d = ST_GRANT;
          // On contention the master that was not served last wins.
          if (m1_req && (!m2_req || last_q == MST_M2)) begin
            m1_grant_d = 1'b1;
          end else begin
            m2_grant_d = 1'b1;
          end
        end
      end
      ST_GRANT: begin
        if (cnt_tc) begin
          err_d      = 1'b1;
          do_release = 1'b1;
          served     = 1'b1;
        end else if (g_valid) begin
          slave_id_d = {g_addr, 1'b0};
          state_d    = ST_SLV_ID;
        end else if (!g_req) begin
          // Abandoned before sending anything: does not count as served.
          do_release = 1'b1;
        end
      end
      ST_SLV_ID: begin
        if (cnt_tc) begin
          err_d      = 1'b1;
          do_release = 1'b1;
          served     = 1'b1;
        end else if (g_valid) begin
          slave_id_d = id_next;
          if (is_valid_slave(id_next, NUM_SLAVES)) begin
            state_d = ST_CONNECT;
          end else begin
            // A bad id still consumed a turn, so fairness moves on.
            err_d      = 1'b1;
            do_release = 1'b1;
            served     = 1'b1;
          end
        end
      end
      ST_CONNECT: begin
        if (cnt_tc) begin
          err_d      = 1'b1;
          do_release = 1'b1;
          served     = 1'b1;
        end else if (sel_done) begin
          do_release = 1'b1;
          served     = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (do_release) begin
      state_d    = ST_IDLE;
      m1_grant_d = 1'b0;
      m2_grant_d = 1'b0;
      if (served) begin
        last_d = m2_grant_q ? MST_M2 : MST_M1;
      end
    end
  end

  // FSM and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      m1_grant_q <= 1'b0;
      m2_grant_q <= 1'b0;
      slave_id_q <= SLV_ID_0;
      last_q     <= MST_M2;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      m1_grant_q <= m1_grant_d;
      m2_grant_q <= m2_grant_d;
      slave_id_q <= slave_id_d;
      last_q     <= last_d;
      err_q      <= err_d;
    end
  end

  // Slave-side valid: only the selected slave, only while connected.
  always_comb begin
    s_valid = '0;
    if (state_q == ST_CONNECT) begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
        if (slave_id_q == SLAVE_ID_W'(i)) begin
          s_valid[i] = g_valid;
        end
      end
    end
  end

  assign s_addr   = g_addr;
  assign s_data   = g_data;
  assign m1_ready = (state_q == ST_CONNECT) && m1_grant_q && sel_ready;
  assign m2_ready = (state_q == ST_CONNECT) && m2_grant_q && sel_ready;
  assign m1_grant = m1_grant_q;
  assign m2_grant = m2_grant_q;
  assign err      = err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_bus_arbiter;

  localparam int TO = 16;
  localparam int NS = 3;

  logic          clk;
  logic          rstn;
  logic          m1_req, m2_req, m1_valid, m2_valid;
  logic          m1_addr, m2_addr, m1_data, m2_data;
  logic          m1_grant, m2_grant, m1_ready, m2_ready;
  logic [NS-1:0] s_valid, s_ready, s_done;
  logic          s_addr, s_data, err;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: owner 0 = none, 1 = m1, 2 = m2.
  int   md_owner, md_taken, md_id, md_age, md_last;
  logic md_err, md_err_next;
  logic gv, ga, gd, greq, connected;
  logic [NS-1:0] exp_sv;

  bus_arbiter #(
    .TIMEOUT    (TO),
    .NUM_SLAVES (NS)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .m1_req   (m1_req),
    .m2_req   (m2_req),
    .m1_valid (m1_valid),
    .m2_valid (m2_valid),
    .m1_addr  (m1_addr),
    .m2_addr  (m2_addr),
    .m1_data  (m1_data),
    .m2_data  (m2_data),
    .m1_grant (m1_grant),
    .m2_grant (m2_grant),
    .m1_ready (m1_ready),
    .m2_ready (m2_ready),
    .s_valid  (s_valid),
    .s_addr   (s_addr),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .s_done   (s_done),
    .err      (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_vec(input string name, input logic [NS-1:0] act, input logic [NS-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m1_req = 0; m2_req = 0; m1_valid = 0; m2_valid = 0;
    m1_addr = 0; m2_addr = 0; m1_data = 0; m2_data = 0;
    s_ready = '0; s_done = '0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  // Compare process: checks every cycle at the falling edge, then advances
  // the model with the inputs the DUT will sample on the next rising edge.
  initial begin
    md_owner = 0; md_taken = 0; md_id = 0; md_age = 0; md_last = 2; md_err = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        md_owner = 0; md_taken = 0; md_id = 0; md_age = 0; md_last = 2; md_err = 0;
      end else begin
        gv = 0; ga = 0; gd = 0; greq = 0;
        if (md_owner == 1) begin gv = m1_valid; ga = m1_addr; gd = m1_data; greq = m1_req; end
        if (md_owner == 2) begin gv = m2_valid; ga = m2_addr; gd = m2_data; greq = m2_req; end
        connected = (md_owner != 0) && (md_taken == 2);
        exp_sv = (connected && gv) ? NS'(1 << md_id) : '0;

        check_bit("m1_grant", m1_grant, md_owner == 1);
        check_bit("m2_grant", m2_grant, md_owner == 2);
        check_bit("err", err, md_err);
        check_vec("s_valid", s_valid, exp_sv);
        check_bit("s_addr", s_addr, ga);
        check_bit("s_data", s_data, gd);
        check_bit("m1_ready", m1_ready, connected && md_owner == 1 && s_ready[md_id]);
        check_bit("m2_ready", m2_ready, connected && md_owner == 2 && s_ready[md_id]);

        md_err_next = 0;
        if (md_owner == 0) begin
          if (m1_req || m2_req) begin
            if (m1_req && m2_req) md_owner = (md_last == 1) ? 2 : 1;
            else md_owner = m1_req ? 1 : 2;
            md_taken = 0;
            md_age   = 0;
          end
        end else begin
          md_age++;
          if (md_age == TO - 1) begin
            md_err_next = 1; md_last = md_owner; md_owner = 0;
          end else if (md_taken < 2 && gv) begin
            md_id = (md_taken == 0) ? int'(ga) : md_id * 2 + int'(ga);
            md_taken++;
            if (md_taken == 2 && md_id >= NS) begin
              md_err_next = 1; md_last = md_owner; md_owner = 0;
            end
          end else if (md_taken == 0 && !greq) begin
            md_owner = 0;
          end else if (md_taken == 2 && s_done[md_id]) begin
            md_last = md_owner; md_owner = 0;
          end
        end
        md_err = md_err_next;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  // Stimulus with literal expectations, then randomized traffic.
  initial begin
    logic [11:0] bits;
    logic p1, p2;

    // Reset state.
    do_reset();
    #2;
    check_bit("rst_m1_grant", m1_grant, 1'b0);
    check_bit("rst_m2_grant", m2_grant, 1'b0);
    check_bit("rst_err", err, 1'b0);
    check_vec("rst_s_valid", s_valid, 3'b000);

    // Single master, slave 1, 12 address bits, done on the last bit.
    tick(); m1_req = 1;
    #2 check_bit("r39_no_grant_yet", m1_grant, 1'b0);
    tick(); m1_valid = 1; m1_addr = 0;
    #2 check_bit("r39_grant", m1_grant, 1'b1);
    check_vec("r39_id1_sv", s_valid, 3'b000);
    tick(); m1_addr = 1;
    #2 check_vec("r39_id0_sv", s_valid, 3'b000);
    bits = 12'hA5C;
    for (int i = 0; i < 12; i++) begin
      tick();
      m1_addr = bits[11 - i];
      m1_data = 1'($urandom_range(1));
      s_ready = 3'b010;
      s_done  = (i == 11) ? 3'b010 : 3'b000;
      #2;
      check_vec("r39_addr_sv", s_valid, 3'b010);
      check_bit("r39_addr_bit", s_addr, bits[11 - i]);
      check_bit("r39_ready", m1_ready, 1'b1);
    end
    tick(); m1_valid = 0; m1_addr = 1; s_done = 0; m1_req = 0;
    #2;
    check_bit("r39_grant_off", m1_grant, 1'b0);
    check_vec("r39_sv_off", s_valid, 3'b000);
    check_bit("r39_addr_idle", s_addr, 1'b0);
    check_bit("r39_no_err", err, 1'b0);

    // Contention after reset, then bad slave id from m2.
    do_reset();
    tick(); m1_req = 1; m2_req = 1;
    tick(); m1_valid = 1; m1_addr = 0;
    #2 check_bit("r40_m1_first", m1_grant, 1'b1);
    check_bit("r40_m2_wait", m2_grant, 1'b0);
    tick(); m1_addr = 0;
    tick(); m1_valid = 0; s_done = 3'b001;
    #2 check_bit("r40_m1_conn", m1_grant, 1'b1);
    tick(); s_done = 0; m1_req = 0;
    #2 check_bit("r40_idle_m1", m1_grant, 1'b0);
    check_bit("r40_idle_m2", m2_grant, 1'b0);
    tick(); m2_valid = 1; m2_addr = 1;
    #2 check_bit("r40_m2_grant", m2_grant, 1'b1);
    check_vec("r41_sv_a", s_valid, 3'b000);
    tick(); m2_addr = 1;
    #2 check_vec("r41_sv_b", s_valid, 3'b000);
    check_bit("r41_err_pre", err, 1'b0);
    tick(); m2_valid = 0; m2_req = 0;
    #2 check_bit("r41_err", err, 1'b1);
    check_bit("r41_grant_off", m2_grant, 1'b0);
    check_vec("r41_sv_c", s_valid, 3'b000);
    tick();
    #2 check_bit("r41_err_pulse", err, 1'b0);

    // Slave never finishes: forced release after TIMEOUT-1 cycles.
    do_reset();
    tick(); m1_req = 1;
    tick(); m1_valid = 1; m1_addr = 0;
    #2 check_bit("r42_grant", m1_grant, 1'b1);
    tick(); m1_addr = 1;
    tick(); m1_valid = 0;
    for (int c = 2; c < TO - 1; c++) begin
      if (c > 2) tick();
      #2;
      check_bit("r42_no_err", err, 1'b0);
      check_bit("r42_held", m1_grant, 1'b1);
    end
    tick(); m1_req = 0;
    #2 check_bit("r42_err", err, 1'b1);
    check_bit("r42_released", m1_grant, 1'b0);
    tick();
    #2 check_bit("r42_err_pulse", err, 1'b0);

    // Asynchronous reset while connected.
    do_reset();
    tick(); m2_req = 1;
    tick(); m2_valid = 1; m2_addr = 1;
    tick(); m2_addr = 0;
    tick(); s_ready = 3'b111;
    #2 check_vec("r43_sv_conn", s_valid, 3'b100);
    check_bit("r43_ready_conn", m2_ready, 1'b1);
    rstn = 0;
    #1;
    check_bit("r43_grant_rst", m2_grant, 1'b0);
    check_vec("r43_sv_rst", s_valid, 3'b000);
    check_bit("r43_ready_rst", m2_ready, 1'b0);
    check_bit("r43_err_rst", err, 1'b0);
    tick(); m1_req = 1; m2_req = 1; m2_valid = 0; s_ready = 0;
    #2 rstn = 1;
    tick();
    #2 check_bit("r43_m1_wins", m1_grant, 1'b1);
    check_bit("r43_m2_waits", m2_grant, 1'b0);

    // Granted master abandons before sending the id.
    do_reset();
    tick(); m1_req = 1;
    tick(); m1_req = 0; m2_req = 1;
    #2 check_bit("r44_m1_grant", m1_grant, 1'b1);
    tick();
    #2 check_bit("r44_m1_off", m1_grant, 1'b0);
    check_bit("r44_m2_idle", m2_grant, 1'b0);
    check_bit("r44_no_err", err, 1'b0);
    tick();
    #2 check_bit("r44_m2_grant", m2_grant, 1'b1);
    check_bit("r44_no_err2", err, 1'b0);

    // Randomized traffic.
    do_reset();
    p1 = 0; p2 = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (m1_req && p1 && !m1_grant && $urandom_range(1) == 0) m1_req = 0;
      else if (!m1_req) m1_req = ($urandom_range(3) == 0);
      else if ($urandom_range(15) == 0) m1_req = 0;
      if (m2_req && p2 && !m2_grant && $urandom_range(1) == 0) m2_req = 0;
      else if (!m2_req) m2_req = ($urandom_range(3) == 0);
      else if ($urandom_range(15) == 0) m2_req = 0;
      m1_valid = m1_req ? 1'($urandom_range(1)) : 1'b0;
      m2_valid = m2_req ? 1'($urandom_range(1)) : 1'b0;
      m1_addr  = 1'($urandom_range(1));
      m2_addr  = 1'($urandom_range(1));
      m1_data  = 1'($urandom_range(1));
      m2_data  = 1'($urandom_range(1));
      s_ready  = NS'($urandom_range(7));
      for (int i = 0; i < NS; i++) s_done[i] = ($urandom_range(7) == 0);
      p1 = m1_grant;
      p2 = m2_grant;
    end

    tick();
    idle_inputs();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
